// File: rtl/temp_sensor_reader_if.sv
// Shared serial bus between the temperature reader and its two sensors.
interface temp_sensor_reader_if;
    logic sensor_sclk;
    logic sensor_sdata;
    logic gh_cs_n;
    logic out_cs_n;

    modport master (
        output sensor_sclk,
        output gh_cs_n,
        output out_cs_n,
        input  sensor_sdata
    );

    modport slave (
        input  sensor_sclk,
        input  gh_cs_n,
        input  out_cs_n,
        output sensor_sdata
    );
endinterface

// File: rtl/temp_sensor_reader.sv
// Polls the greenhouse and then the outside serial sensor, validates each 10-bit
// frame and publishes the latest good readings to the temperature controller.
module temp_sensor_reader #(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 1000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_en,
    temp_sensor_reader_if.master        sensor,
    output logic [7:0]                  greenhouse_temp,
    output logic [7:0]                  outside_temp,
    output logic                        temp_g_greenhouse_temp,
    output logic                        sample_valid,
    output logic                        parity_err,
    output logic [7:0]                  err_count
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] GH_SETUP  = 3'd1;
    localparam logic [2:0] GH_SHIFT  = 3'd2;
    localparam logic [2:0] GH_HOLD   = 3'd3;
    localparam logic [2:0] OUT_SETUP = 3'd4;
    localparam logic [2:0] OUT_SHIFT = 3'd5;
    localparam logic [2:0] OUT_HOLD  = 3'd6;
    localparam logic [2:0] UPDATE    = 3'd7;

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int CNT_W = $clog2(SAMPLE_PERIOD);
    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(CLK_DIV - 1);
    // Idle dwell chosen so conversion starts are exactly SAMPLE_PERIOD apart.
    localparam logic [CNT_W-1:0] PERIOD_TERM = CNT_W'(SAMPLE_PERIOD - 44 * CLK_DIV - 2);

    // Start bit must be 0 and data plus parity must hold an even number of ones.
    function automatic logic frame_ok(input logic [9:0] frame);
        return (frame[9] == 1'b0) && ((^frame[8:0]) == 1'b0);
    endfunction

    logic [2:0]       state_r;
    logic [CNT_W-1:0] period_cnt_r;
    logic [DIV_W-1:0] div_cnt_r;
    logic [4:0]       half_cnt_r;
    logic             sclk_r;
    logic             gh_cs_n_r;
    logic             out_cs_n_r;
    logic [9:0]       shift_r;
    logic [9:0]       gh_frame_r;
    logic [7:0]       gh_temp_r;
    logic [7:0]       out_temp_r;
    logic             flag_r;
    logic             sample_valid_r;
    logic             parity_err_r;
    logic [7:0]       err_count_r;

    logic             div_done_s;
    logic             gh_ok_s;
    logic             out_ok_s;
    logic [1:0]       bad_cnt_s;
    logic [8:0]       err_sum_s;
    logic [7:0]       err_next_s;

    // Frame validation and saturating error accumulation for the UPDATE cycle.
    always_comb begin
        div_done_s = (div_cnt_r == DIV_LAST);
        gh_ok_s    = frame_ok(gh_frame_r);
        out_ok_s   = frame_ok(shift_r);
        bad_cnt_s  = {1'b0, ~gh_ok_s} + {1'b0, ~out_ok_s};
        err_sum_s  = {1'b0, err_count_r} + {7'b0, bad_cnt_s};
        if (err_sum_s[8]) begin
            err_next_s = 8'hFF;
        end else begin
            err_next_s = err_sum_s[7:0];
        end
    end

    // Sequencer: period timer, chip selects, serial clock and frame capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            period_cnt_r <= {CNT_W{1'b0}};
            div_cnt_r    <= {DIV_W{1'b0}};
            half_cnt_r   <= 5'd0;
            sclk_r       <= 1'b0;
            gh_cs_n_r    <= 1'b1;
            out_cs_n_r   <= 1'b1;
            shift_r      <= 10'd0;
            gh_frame_r   <= 10'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    div_cnt_r <= {DIV_W{1'b0}};
                    if (!start_en) begin
                        period_cnt_r <= {CNT_W{1'b0}};
                    end else if (period_cnt_r == PERIOD_TERM) begin
                        period_cnt_r <= {CNT_W{1'b0}};
                        gh_cs_n_r    <= 1'b0;
                        state_r      <= GH_SETUP;
                    end else begin
                        period_cnt_r <= period_cnt_r + CNT_W'(1);
                    end
                end
                GH_SETUP, OUT_SETUP: begin
                    if (div_done_s) begin
                        div_cnt_r  <= {DIV_W{1'b0}};
                        half_cnt_r <= 5'd0;
                        state_r    <= (state_r == GH_SETUP) ? GH_SHIFT : OUT_SHIFT;
                    end else begin
                        div_cnt_r <= div_cnt_r + DIV_W'(1);
                    end
                end
                GH_SHIFT, OUT_SHIFT: begin
                    if (div_done_s) begin
                        div_cnt_r <= {DIV_W{1'b0}};
                        // The 20th half-period is high; its falling edge is the HOLD entry.
                        if (half_cnt_r == 5'd19) begin
                            sclk_r  <= 1'b0;
                            state_r <= (state_r == GH_SHIFT) ? GH_HOLD : OUT_HOLD;
                        end else begin
                            sclk_r     <= ~sclk_r;
                            half_cnt_r <= half_cnt_r + 5'd1;
                            if (!sclk_r) begin
                                shift_r <= {shift_r[8:0], sensor.sensor_sdata};
                            end else begin
                                shift_r <= shift_r;
                            end
                        end
                    end else begin
                        div_cnt_r <= div_cnt_r + DIV_W'(1);
                    end
                end
                GH_HOLD: begin
                    if (div_done_s) begin
                        div_cnt_r  <= {DIV_W{1'b0}};
                        gh_frame_r <= shift_r;
                        gh_cs_n_r  <= 1'b1;
                        out_cs_n_r <= 1'b0;
                        state_r    <= OUT_SETUP;
                    end else begin
                        div_cnt_r <= div_cnt_r + DIV_W'(1);
                    end
                end
                OUT_HOLD: begin
                    if (div_done_s) begin
                        div_cnt_r  <= {DIV_W{1'b0}};
                        out_cs_n_r <= 1'b1;
                        state_r    <= UPDATE;
                    end else begin
                        div_cnt_r <= div_cnt_r + DIV_W'(1);
                    end
                end
                UPDATE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r    <= IDLE;
                    sclk_r     <= 1'b0;
                    gh_cs_n_r  <= 1'b1;
                    out_cs_n_r <= 1'b1;
                end
            endcase
        end
    end

    // Result registers: readings, status pulses and error counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            gh_temp_r      <= 8'd0;
            out_temp_r     <= 8'd0;
            sample_valid_r <= 1'b0;
            parity_err_r   <= 1'b0;
            err_count_r    <= 8'd0;
        end else if (state_r == UPDATE) begin
            gh_temp_r      <= gh_ok_s ? gh_frame_r[8:1] : gh_temp_r;
            out_temp_r     <= out_ok_s ? shift_r[8:1] : out_temp_r;
            sample_valid_r <= gh_ok_s & out_ok_s;
            parity_err_r   <= ~(gh_ok_s & out_ok_s);
            err_count_r    <= err_next_s;
        end else begin
            sample_valid_r <= 1'b0;
            parity_err_r   <= 1'b0;
        end
    end

    // Outside-warmer flag follows the published readings one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_r <= 1'b0;
        end else begin
            flag_r <= (out_temp_r > gh_temp_r);
        end
    end

    assign sensor.sensor_sclk     = sclk_r;
    assign sensor.gh_cs_n         = gh_cs_n_r;
    assign sensor.out_cs_n        = out_cs_n_r;
    assign greenhouse_temp        = gh_temp_r;
    assign outside_temp           = out_temp_r;
    assign temp_g_greenhouse_temp = flag_r;
    assign sample_valid           = sample_valid_r;
    assign parity_err             = parity_err_r;
    assign err_count              = err_count_r;

endmodule

// File: tb/tb_temp_sensor_reader.sv
// Self-checking bench: behavioural sensors, table-driven and random conversions,
// reset/enable corner cases, and a fast second instance for counter saturation.
module tb_temp_sensor_reader;

    logic clk;
    logic rst;
    logic rst2;
    logic start_en;
    logic start_en2;
    logic [7:0] gh_t, out_t, errc, gh_t2, out_t2, errc2;
    logic flag, sv, pe, flag2, sv2, pe2;

    temp_sensor_reader_if bus();
    temp_sensor_reader_if bus2();

    temp_sensor_reader dut (
        .clk(clk), .rst(rst), .start_en(start_en), .sensor(bus),
        .greenhouse_temp(gh_t), .outside_temp(out_t),
        .temp_g_greenhouse_temp(flag), .sample_valid(sv),
        .parity_err(pe), .err_count(errc)
    );

    temp_sensor_reader #(.CLK_DIV(2), .SAMPLE_PERIOD(90)) dut2 (
        .clk(clk), .rst(rst2), .start_en(start_en2), .sensor(bus2),
        .greenhouse_temp(gh_t2), .outside_temp(out_t2),
        .temp_g_greenhouse_temp(flag2), .sample_valid(sv2),
        .parity_err(pe2), .err_count(errc2)
    );

    typedef struct {
        logic [9:0] g;
        logic [9:0] o;
        logic [7:0] gh;
        logic [7:0] ot;
        logic       valid;
        logic [7:0] err;
        logic       flag;
    } vec_t;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [9:0] gh_frame, out_frame;
    bit sat_done = 1'b0;

    // Reference model state (what the outputs should hold after each UPDATE).
    int m_gh, m_out, m_err;
    bit m_flag;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit fr_ok(input logic [9:0] f);
        return (f[9] == 1'b0) && (($countones(f[8:0]) % 2) == 0);
    endfunction

    function automatic logic [9:0] mk_frame(input logic [7:0] d, input int mode);
        logic s;
        logic p;
        s = (mode == 3);
        p = (^d) ^ (mode == 2);
        return {s, d, p};
    endfunction

    task automatic model_step(input logic [9:0] g, input logic [9:0] o,
                              output int e_gh, output int e_out, output bit e_valid,
                              output int e_err, output bit e_flag, output bit p_flag);
        int bad;
        bad = 0;
        p_flag = m_flag;
        if (fr_ok(g)) m_gh = int'(g[8:1]); else bad++;
        if (fr_ok(o)) m_out = int'(o[8:1]); else bad++;
        m_err = (m_err + bad > 255) ? 255 : m_err + bad;
        m_flag = (m_out > m_gh);
        e_gh = m_gh; e_out = m_out; e_valid = (bad == 0);
        e_err = m_err; e_flag = m_flag;
    endtask

    // Behavioural sensors: first bit on select fall, next bit after each sclk fall.
    initial begin
        int bit_idx;
        logic prev_sclk, prev_gh, prev_out;
        bit_idx = 9; prev_sclk = 1'b0; prev_gh = 1'b1; prev_out = 1'b1;
        bus.sensor_sdata = 1'b1;
        forever begin
            step();
            if (bus.gh_cs_n === 1'b0 && prev_gh === 1'b1) begin
                bit_idx = 0; bus.sensor_sdata = gh_frame[9];
            end else if (bus.out_cs_n === 1'b0 && prev_out === 1'b1) begin
                bit_idx = 0; bus.sensor_sdata = out_frame[9];
            end else if (prev_sclk === 1'b1 && bus.sensor_sclk === 1'b0 && bit_idx < 9) begin
                bit_idx++;
                bus.sensor_sdata = (bus.gh_cs_n === 1'b0) ? gh_frame[9-bit_idx] : out_frame[9-bit_idx];
            end
            prev_sclk = bus.sensor_sclk; prev_gh = bus.gh_cs_n; prev_out = bus.out_cs_n;
        end
    end

    // One conversion: wait for T0, check pin timing per cycle, then the results.
    task automatic do_conv(input logic [9:0] g, input logic [9:0] o, input int drop_at,
                           input int e_gh, input int e_out, input bit e_valid,
                           input int e_err, input bit e_flag, input bit p_flag, output int t0);
        int waited, gh_bad, out_bad, gr, orr, first, overlap, idle_sclk, early;
        logic prev_s;
        gh_frame = g; out_frame = o;
        waited = 0;
        while (bus.gh_cs_n !== 1'b0 && waited < 1100) begin
            step(); waited++;
        end
        check("t0_found", 32'(waited < 1100), 32'd1);
        t0 = cyc;
        if (waited >= 1100) return;
        gh_bad = 0; out_bad = 0; gr = 0; orr = 0; first = -1;
        overlap = 0; idle_sclk = 0; early = 0; prev_s = 1'b0;
        for (int k = 0; k <= 178; k++) begin
            if (k == drop_at) start_en = 1'b0;
            if (bus.gh_cs_n !== ((k < 88) ? 1'b0 : 1'b1)) gh_bad++;
            if (bus.out_cs_n !== ((k >= 88 && k < 176) ? 1'b0 : 1'b1)) out_bad++;
            if (bus.sensor_sclk === 1'b1 && prev_s === 1'b0) begin
                if (k < 88) gr++; else orr++;
                if (first < 0) first = k;
            end
            if (bus.gh_cs_n === 1'b0 && bus.out_cs_n === 1'b0) overlap++;
            if (bus.gh_cs_n === 1'b1 && bus.out_cs_n === 1'b1 && bus.sensor_sclk !== 1'b0) idle_sclk++;
            if (k < 177 && (sv !== 1'b0 || pe !== 1'b0)) early++;
            if (k == 177) begin
                check("greenhouse_temp", 32'(gh_t), 32'(e_gh));
                check("outside_temp", 32'(out_t), 32'(e_out));
                check("sample_valid", 32'(sv), 32'(e_valid));
                check("parity_err", 32'(pe), 32'(!e_valid));
                check("err_count", 32'(errc), 32'(e_err));
                check("flag_not_early", 32'(flag), 32'(p_flag));
            end
            if (k == 178) begin
                check("flag", 32'(flag), 32'(e_flag));
                check("pulse_one_cycle", 32'({sv, pe}), 32'd0);
            end
            prev_s = bus.sensor_sclk;
            if (k < 178) step();
        end
        check("gh_cs_pattern", 32'(gh_bad), 32'd0);
        check("out_cs_pattern", 32'(out_bad), 32'd0);
        check("gh_sclk_rises", 32'(gr), 32'd10);
        check("out_sclk_rises", 32'(orr), 32'd10);
        check("first_rise", 32'(first), 32'd8);
        check("select_overlap", 32'(overlap), 32'd0);
        check("sclk_idle_low", 32'(idle_sclk), 32'd0);
        check("pulse_early", 32'(early), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_sclk"}, 32'(bus.sensor_sclk), 32'd0);
        check({tag, "_cs"}, 32'({bus.gh_cs_n, bus.out_cs_n}), 32'd3);
        check({tag, "_temps"}, 32'({gh_t, out_t}), 32'd0);
        check({tag, "_flag"}, 32'(flag), 32'd0);
        check({tag, "_pulses"}, 32'({sv, pe}), 32'd0);
        check({tag, "_err"}, 32'(errc), 32'd0);
    endtask

    // Saturation on a fast instance whose data line always gives bad start bits.
    initial begin
        int e2, pulses, waited;
        e2 = 0; pulses = 0; waited = 0;
        rst2 = 1'b1; start_en2 = 1'b1; bus2.sensor_sdata = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst2 = 1'b0;
        while (pulses < 130 && waited < 130 * 90 + 1000) begin
            step(); waited++;
            if (pe2 === 1'b1) begin
                pulses++;
                e2 = (e2 + 2 > 255) ? 255 : e2 + 2;
                check("sat_err_count", 32'(errc2), 32'(e2));
            end
        end
        check("sat_pulses", 32'(pulses), 32'd130);
        check("sat_final", 32'(errc2), 32'd255);
        check("sat_temps", 32'({gh_t2, out_t2}), 32'd0);
        sat_done = 1'b1;
    end

    initial begin
        vec_t tbl[4];
        int t0, prev_t0, rel, e_gh, e_out, e_err, cnt, waited;
        bit e_valid, e_flag, p_flag;
        logic [7:0] dg, dout;

        tbl[0] = '{g: {1'b0, 8'h46, 1'b1}, o: {1'b0, 8'h5A, 1'b0}, gh: 8'd70, ot: 8'd90, valid: 1'b1, err: 8'd0, flag: 1'b1};
        tbl[1] = '{g: {1'b0, 8'h46, 1'b0}, o: {1'b0, 8'h20, 1'b1}, gh: 8'd70, ot: 8'd32, valid: 1'b0, err: 8'd1, flag: 1'b0};
        tbl[2] = '{g: {1'b1, 8'h11, 1'b0}, o: {1'b1, 8'h99, 1'b0}, gh: 8'd70, ot: 8'd32, valid: 1'b0, err: 8'd3, flag: 1'b0};
        tbl[3] = '{g: {1'b0, 8'h50, 1'b0}, o: {1'b0, 8'h50, 1'b0}, gh: 8'd80, ot: 8'd80, valid: 1'b1, err: 8'd3, flag: 1'b0};

        m_gh = 0; m_out = 0; m_err = 0; m_flag = 1'b0;
        gh_frame = 10'd0; out_frame = 10'd0;
        rst = 1'b1; start_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        rel = cyc;
        check_reset_vals("reset");

        prev_t0 = 0;
        for (int i = 0; i < 4; i++) begin
            model_step(tbl[i].g, tbl[i].o, e_gh, e_out, e_valid, e_err, e_flag, p_flag);
            do_conv(tbl[i].g, tbl[i].o, -1, int'(tbl[i].gh), int'(tbl[i].ot), tbl[i].valid,
                    int'(tbl[i].err), tbl[i].flag, (i == 0) ? 1'b0 : tbl[i-1].flag, t0);
            if (i == 0) check("first_start", 32'(t0 - rel), 32'd823);
            else check("start_spacing", 32'(t0 - prev_t0), 32'd1000);
            prev_t0 = t0;
        end

        for (int i = 0; i < 6; i++) begin
            logic [9:0] g, o;
            dg = 8'($urandom_range(0, 255)); dout = 8'($urandom_range(0, 255));
            g = mk_frame(dg, int'($urandom_range(0, 3)));
            o = mk_frame(dout, int'($urandom_range(0, 3)));
            model_step(g, o, e_gh, e_out, e_valid, e_err, e_flag, p_flag);
            do_conv(g, o, -1, e_gh, e_out, e_valid, e_err, e_flag, p_flag, t0);
            check("rand_spacing", 32'(t0 - prev_t0), 32'd1000);
            prev_t0 = t0;
        end

        // start_en dropped mid-conversion: finishes, then stays idle.
        dg = 8'($urandom_range(0, 255)); dout = 8'($urandom_range(0, 255));
        model_step(mk_frame(dg, 0), mk_frame(dout, 0), e_gh, e_out, e_valid, e_err, e_flag, p_flag);
        do_conv(mk_frame(dg, 0), mk_frame(dout, 0), 100, e_gh, e_out, e_valid, e_err, e_flag, p_flag, t0);
        check("drop_spacing", 32'(t0 - prev_t0), 32'd1000);
        cnt = 0;
        for (int k = 0; k < 1200; k++) begin
            step();
            if (bus.gh_cs_n !== 1'b1 || bus.out_cs_n !== 1'b1 || sv !== 1'b0 || pe !== 1'b0) cnt++;
        end
        check("idle_after_drop", 32'(cnt), 32'd0);

        // Re-enable, then reset in the middle of the greenhouse shift.
        start_en = 1'b1;
        rel = cyc;
        gh_frame = mk_frame(8'h30, 0); out_frame = mk_frame(8'h10, 0);
        waited = 0;
        while (bus.gh_cs_n !== 1'b0 && waited < 1100) begin
            step(); waited++;
        end
        check("reenable_start", 32'(cyc - rel), 32'd823);
        repeat (40) step();
        rst = 1'b1;
        step();
        check_reset_vals("midshift_rst");
        rst = 1'b0;
        rel = cyc;
        m_gh = 0; m_out = 0; m_err = 0; m_flag = 1'b0;
        cnt = 0;
        for (int k = 0; k < 200; k++) begin
            step();
            if (sv !== 1'b0 || pe !== 1'b0 || bus.gh_cs_n !== 1'b1) cnt++;
        end
        check("no_pulse_after_rst", 32'(cnt), 32'd0);
        dg = 8'($urandom_range(0, 255)); dout = 8'($urandom_range(0, 255));
        model_step(mk_frame(dg, 0), mk_frame(dout, 2), e_gh, e_out, e_valid, e_err, e_flag, p_flag);
        do_conv(mk_frame(dg, 0), mk_frame(dout, 2), -1, e_gh, e_out, e_valid, e_err, e_flag, p_flag, t0);
        check("restart_after_rst", 32'(t0 - rel), 32'd823);

        waited = 0;
        while (!sat_done && waited < 20000) begin
            step(); waited++;
        end
        check("sat_finished", 32'(sat_done), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
